// File: rtl/ii_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ii_display_pkg
//  Description : Shared definitions for the integral-image display path:
//                display-mode encodings, grid overlay colour and a constant
//                ceil(log2) helper used to size counters.
//  Revision    : 1.0  initial release
// ============================================================================
package ii_display_pkg;

    typedef enum logic [1:0] {
        MODE_PIX     = 2'd0,
        MODE_II      = 2'd1,
        MODE_ROWDIFF = 2'd2,
        MODE_BLACK   = 2'd3
    } mode_e;

    localparam logic [11:0] GRID_COLOR = 12'hF00;

    // Never returns less than 1 so that a range of one value still gets a
    // legal one-bit counter.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ii_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : ii_line_buffer
//  Description : Single-port previous-row store for the II display path.
//                One address per cycle; a read and a write in the same cycle
//                return the old contents (read-before-write).
//  Ports       : clk_vga  pixel clock
//                i_addr   column index
//                i_we     write strobe
//                i_wdata  II word to store
//                o_rdata  II word currently stored at i_addr
//  Revision    : 1.0  initial release
// ============================================================================
module ii_line_buffer #(
    parameter int DEPTH = 160,
    parameter int DW    = 20,
    parameter int AW    = 8
) (
    input  logic          clk_vga,
    input  logic [AW-1:0] i_addr,
    input  logic          i_we,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_vga) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/ii_display_engine.sv
`default_nettype none
// ============================================================================
//  Module      : ii_display_engine
//  Description : Reads an integral-image frame, reconstructs each source
//                pixel from four II samples, replicates it SCALE x SCALE and
//                drives 12-bit greyscale RGB.
//  Ports       : clk_vga, rst (sync, active-high), vsync (active-low frame
//                restart), active (VGA active area), mode (display select),
//                rd_addr/rd_en/rd_data (II memory read port),
//                rgb/rgb_valid (pixel out), frame_done (end-of-frame pulse)
//  Options     : II_DISPLAY_GRID_EN  red grid overlay every 16 source px
//  Revision    : 1.0  initial release
// ============================================================================
module ii_display_engine
    import ii_display_pkg::*;
#(
    parameter int II_WIDTH  = 160,
    parameter int II_HEIGHT = 120,
    parameter int II_DW     = 20,
    parameter int PIX_DW    = 8,
    parameter int SCALE     = 4,
    parameter int RD_LAT    = 1,
    parameter int AW        = 15
) (
    input  logic             clk_vga,
    input  logic             rst,
    input  logic             vsync,
    input  logic             active,
    input  logic [1:0]       mode,
    output logic [AW-1:0]    rd_addr,
    output logic             rd_en,
    input  logic [II_DW-1:0] rd_data,
    output logic [11:0]      rgb,
    output logic             rgb_valid,
    output logic             frame_done
);

    localparam int c_SX_W  = clog2(SCALE);
    localparam int c_COL_W = clog2(II_WIDTH);
    localparam int c_ROW_W = clog2(II_HEIGHT);
    localparam int c_LAST  = RD_LAT - 1;
    localparam logic [c_SX_W-1:0]  c_SX_MAX  = c_SX_W'(SCALE - 1);
    localparam logic [c_COL_W-1:0] c_COL_MAX = c_COL_W'(II_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_MAX = c_ROW_W'(II_HEIGHT - 1);

    // ---------------------------------------------------------------- counters
    logic [c_SX_W-1:0]  r_sub_x, r_sub_y;
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [AW-1:0]      r_line_base;   // row * II_WIDTH, kept incrementally
    logic               r_done;
    mode_e              r_mode;

    logic w_clear, w_step, w_issue;
    logic w_sx_wrap, w_col_wrap, w_sy_wrap, w_row_wrap;

    assign w_clear    = rst || !vsync;
    assign w_step     = active && !r_done;
    assign w_sx_wrap  = (r_sub_x == c_SX_MAX);
    assign w_col_wrap = w_sx_wrap && (r_col == c_COL_MAX);
    assign w_sy_wrap  = w_col_wrap && (r_sub_y == c_SX_MAX);
    assign w_row_wrap = w_sy_wrap && (r_row == c_ROW_MAX);
    assign w_issue    = w_step && !w_clear && (r_sub_x == '0);

    always_ff @(posedge clk_vga) begin
        if (w_clear) begin
            r_sub_x     <= '0;
            r_sub_y     <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_line_base <= '0;
            r_done      <= 1'b0;
        end else if (w_step) begin
            if (w_row_wrap) begin
                // Last output pixel of the frame: counters hold where they are.
                r_done <= 1'b1;
            end else begin
                r_sub_x <= w_sx_wrap ? '0 : r_sub_x + c_SX_W'(1);
                if (w_sx_wrap)
                    r_col <= w_col_wrap ? '0 : r_col + c_COL_W'(1);
                if (w_col_wrap)
                    r_sub_y <= w_sy_wrap ? '0 : r_sub_y + c_SX_W'(1);
                if (w_sy_wrap) begin
                    r_row       <= r_row + c_ROW_W'(1);
                    r_line_base <= r_line_base + AW'(II_WIDTH);
                end
            end
        end
    end

    // Pulse survives a coincident vsync; only a real reset suppresses it.
    always_ff @(posedge clk_vga) begin
        if (rst) frame_done <= 1'b0;
        else     frame_done <= w_step && w_row_wrap;
    end

    always_ff @(posedge clk_vga) begin
        if (rst)         r_mode <= MODE_PIX;
        else if (!vsync) r_mode <= mode_e'(mode);
    end

    assign rd_en   = w_issue;
    assign rd_addr = w_issue ? (r_line_base + AW'(r_col)) : '0;

    // ---------------------------------------------------------- tag pipeline
    // One stage per cycle of memory latency so the tags at index c_LAST line
    // up with the returning rd_data.
    logic               r_tag_vld  [RD_LAT];
    logic               r_tag_act  [RD_LAT];
    logic               r_tag_blk  [RD_LAT];
    logic               r_tag_first[RD_LAT];
    logic               r_tag_top  [RD_LAT];
    logic               r_tag_wr   [RD_LAT];
    logic [c_COL_W-1:0] r_tag_col  [RD_LAT];
`ifdef II_DISPLAY_GRID_EN
    logic               r_tag_grid [RD_LAT];
    logic               w_grid_in;
    assign w_grid_in = ((int'(r_col) % 16 == 0) && (r_sub_x == '0)) ||
                       ((int'(r_row) % 16 == 0) && (r_sub_y == '0));
`endif

    always_ff @(posedge clk_vga) begin
        if (w_clear) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_tag_vld[i]   <= 1'b0;
                r_tag_act[i]   <= 1'b0;
                r_tag_blk[i]   <= 1'b0;
                r_tag_first[i] <= 1'b0;
                r_tag_top[i]   <= 1'b0;
                r_tag_wr[i]    <= 1'b0;
                r_tag_col[i]   <= '0;
`ifdef II_DISPLAY_GRID_EN
                r_tag_grid[i]  <= 1'b0;
`endif
            end
        end else begin
            r_tag_vld[0]   <= w_issue;
            r_tag_act[0]   <= active;
            r_tag_blk[0]   <= active && r_done;
            r_tag_first[0] <= (r_col == '0);
            r_tag_top[0]   <= (r_row == '0);
            r_tag_wr[0]    <= (r_sub_y == c_SX_MAX);
            r_tag_col[0]   <= r_col;
`ifdef II_DISPLAY_GRID_EN
            r_tag_grid[0]  <= w_grid_in;
`endif
            for (int i = 1; i < RD_LAT; i++) begin
                r_tag_vld[i]   <= r_tag_vld[i-1];
                r_tag_act[i]   <= r_tag_act[i-1];
                r_tag_blk[i]   <= r_tag_blk[i-1];
                r_tag_first[i] <= r_tag_first[i-1];
                r_tag_top[i]   <= r_tag_top[i-1];
                r_tag_wr[i]    <= r_tag_wr[i-1];
                r_tag_col[i]   <= r_tag_col[i-1];
`ifdef II_DISPLAY_GRID_EN
                r_tag_grid[i]  <= r_tag_grid[i-1];
`endif
            end
        end
    end

    // ---------------------------------------------------------- reconstruction
    logic [II_DW-1:0]  w_lb_rdata, w_prev, w_left_cur, w_left_prev;
    logic [II_DW-1:0]  r_left_cur, r_left_prev;
    logic [PIX_DW-1:0] w_pix, w_sel;
    logic [3:0]        w_g_new, w_g, r_hold_g;

    ii_line_buffer #(
        .DEPTH (II_WIDTH),
        .DW    (II_DW),
        .AW    (c_COL_W)
    ) u_line_buffer (
        .clk_vga (clk_vga),
        .i_addr  (r_tag_col[c_LAST]),
        .i_we    (r_tag_vld[c_LAST] && r_tag_wr[c_LAST]),
        .i_wdata (rd_data),
        .o_rdata (w_lb_rdata)
    );

    // Row 0 has nothing above it, whatever the buffer still holds from an
    // earlier (possibly aborted) frame.
    assign w_prev      = r_tag_top[c_LAST]   ? '0 : w_lb_rdata;
    assign w_left_cur  = r_tag_first[c_LAST] ? '0 : r_left_cur;
    assign w_left_prev = r_tag_first[c_LAST] ? '0 : r_left_prev;
    assign w_pix       = PIX_DW'(rd_data - w_left_cur - w_prev + w_left_prev);

    always_comb begin
        w_sel = '0;
        case (r_mode)
            MODE_PIX:     w_sel = w_pix;
            MODE_II:      w_sel = PIX_DW'(rd_data >> (II_DW - PIX_DW));
            MODE_ROWDIFF: w_sel = PIX_DW'(rd_data - w_prev);
            default:      w_sel = '0;
        endcase
    end

    assign w_g_new = 4'(w_sel >> (PIX_DW - 4));
    // Non-read cycles of a replicated pixel repeat the last fetched value.
    assign w_g     = r_tag_vld[c_LAST] ? w_g_new : r_hold_g;

    always_ff @(posedge clk_vga) begin
        if (w_clear) begin
            r_left_cur  <= '0;
            r_left_prev <= '0;
            r_hold_g    <= '0;
            rgb         <= '0;
            rgb_valid   <= 1'b0;
        end else begin
            if (r_tag_vld[c_LAST]) begin
                r_left_cur  <= rd_data;
                r_left_prev <= w_prev;
                r_hold_g    <= w_g_new;
            end
            if (!r_tag_act[c_LAST] || r_tag_blk[c_LAST]) begin
                rgb       <= '0;
                rgb_valid <= 1'b0;
            end else begin
                rgb_valid <= 1'b1;
                rgb       <= {w_g, w_g, w_g};
`ifdef II_DISPLAY_GRID_EN
                if (r_tag_grid[c_LAST] && (r_mode != MODE_BLACK))
                    rgb <= GRID_COLOR;
`endif
            end
        end
    end

endmodule
`default_nettype wire
